result_tx_serializer: RTL and testbench

- Downstream stage of the vector-processor control unit.
- On a `tx_start` pulse it latches the result of the operation selected by the one-hot `enables` bus and splits it into bytes, MSB first.
- Each byte goes through the UART transmitter handshake. When the last byte is out, it returns a one-cycle `tx_sent` pulse, which the control unit uses to advance its element counter or return to IDLE.

---
 rtl/vec_pkg.sv | 30 +++
 rtl/result_mux.sv | 44 ++++
 rtl/result_tx_serializer.sv | 177 +++++++++++++++++
 tb/tb_result_tx_serializer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared vector-processor constants: op indices, per-op result byte counts and
// the result serializer state encoding.
package vec_pkg;

    localparam int RES_W_DEFAULT = 32;
    localparam int SHIFT_W       = 32;

    localparam int OP_READ = 0;
    localparam int OP_SUM  = 1;
    localparam int OP_AVG  = 2;
    localparam int OP_EUC  = 3;
    localparam int OP_MAN  = 4;
    localparam int OP_DOT  = 5;

    localparam logic [2:0] BYTES_READ = 3'd1;
    localparam logic [2:0] BYTES_SUM  = 3'd2;
    localparam logic [2:0] BYTES_AVG  = 3'd1;
    localparam logic [2:0] BYTES_EUC  = 3'd2;
    localparam logic [2:0] BYTES_MAN  = 3'd3;
    localparam logic [2:0] BYTES_DOT  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_ACCEPT,
        S_WAIT_DONE
    } ser_state_t;

endpackage

// File: rtl/result_mux.sv
// Priority one-hot result select (lowest enables index wins); returns the
// selected result word and how many of its low bytes are meaningful.
module result_mux
    import vec_pkg::*;
#(
    parameter int RES_W = RES_W_DEFAULT
) (
    input  logic [5:0]       i_enables,
    input  logic [RES_W-1:0] i_read_res,
    input  logic [RES_W-1:0] i_sum_res,
    input  logic [RES_W-1:0] i_avg_res,
    input  logic [RES_W-1:0] i_euc_res,
    input  logic [RES_W-1:0] i_man_res,
    input  logic [RES_W-1:0] i_dot_res,
    output logic [RES_W-1:0] o_word,
    output logic [2:0]       o_bytes
);

    always_comb begin
        // NOTE: every output gets a default before the if-chain so no path leaves it unassigned (no latch).
        o_word  = '0;
        o_bytes = 3'd0;
        if (i_enables[OP_READ]) begin
            o_word  = i_read_res;
            o_bytes = BYTES_READ;
        end else if (i_enables[OP_SUM]) begin
            o_word  = i_sum_res;
            o_bytes = BYTES_SUM;
        end else if (i_enables[OP_AVG]) begin
            o_word  = i_avg_res;
            o_bytes = BYTES_AVG;
        end else if (i_enables[OP_EUC]) begin
            o_word  = i_euc_res;
            o_bytes = BYTES_EUC;
        end else if (i_enables[OP_MAN]) begin
            o_word  = i_man_res;
            o_bytes = BYTES_MAN;
        end else if (i_enables[OP_DOT]) begin
            o_word  = i_dot_res;
            o_bytes = BYTES_DOT;
        end
    end

endmodule

// File: rtl/result_tx_serializer.sv
// Serializes the selected operation result MSB-first over the UART TX handshake.
// Optional per-byte watchdog enabled by defining TX_TIMEOUT_EN.
module result_tx_serializer
    import vec_pkg::*;
#(
    parameter int RES_W          = RES_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_start,
    input  logic [5:0]       enables,
    input  logic [RES_W-1:0] read_res,
    input  logic [RES_W-1:0] sum_res,
    input  logic [RES_W-1:0] avg_res,
    input  logic [RES_W-1:0] euc_res,
    input  logic [RES_W-1:0] man_res,
    input  logic [RES_W-1:0] dot_res,
    input  logic             uart_ready,
    output logic             uart_valid,
    output logic [7:0]       uart_data,
    output logic             tx_sent,
    output logic             busy,
    output logic             timeout_err
);

    ser_state_t         r_state;
    ser_state_t         w_state_next;
    logic [SHIFT_W-1:0] r_shift;
    logic [2:0]         r_remaining;
    logic               r_tx_sent;
    logic [RES_W-1:0]   w_mux_word;
    logic [2:0]         w_mux_bytes;
    logic               w_accept;
    logic               w_shift_en;
    logic               w_finish;
    logic               w_abort;

    result_mux #(.RES_W(RES_W)) u_result_mux (
        .i_enables  (enables),
        .i_read_res (read_res),
        .i_sum_res  (sum_res),
        .i_avg_res  (avg_res),
        .i_euc_res  (euc_res),
        .i_man_res  (man_res),
        .i_dot_res  (dot_res),
        .o_word     (w_mux_word),
        .o_bytes    (w_mux_bytes)
    );

`ifdef TX_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] r_timer;
    logic               r_timeout_err;
    logic               w_timeout_hit;

    assign w_timeout_hit = ((r_state == S_WAIT_ACCEPT) || (r_state == S_WAIT_DONE))
                           && (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            // Counts only while waiting on the UART; each new byte restarts the budget.
            if ((r_state == S_WAIT_ACCEPT) || (r_state == S_WAIT_DONE))
                r_timer <= r_timer + 1'b1;
            else
                r_timer <= '0;
            if (w_timeout_hit)
                r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        uart_valid   = 1'b0;
        w_accept     = 1'b0;
        w_shift_en   = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A start coinciding with the tx_sent pulse is dropped.
                if (tx_start && !r_tx_sent) begin
                    w_accept     = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_remaining == 3'd0) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (uart_ready) begin
                    uart_valid   = 1'b1;
                    w_state_next = S_WAIT_ACCEPT;
                end
            end
            S_WAIT_ACCEPT: begin
                if (!uart_ready)
                    w_state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (uart_ready) begin
                    w_shift_en = 1'b1;
                    if (r_remaining == 3'd1) begin
                        w_finish     = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_ISSUE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
`ifdef TX_TIMEOUT_EN
        if (w_timeout_hit) begin
            w_shift_en   = 1'b0;
            w_abort      = 1'b1;
            w_finish     = 1'b1;
            w_state_next = S_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift     <= '0;
            r_remaining <= 3'd0;
            r_tx_sent   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees pre-edge values.
            r_tx_sent <= w_finish;
            if (w_accept) begin
                r_shift     <= SHIFT_W'(w_mux_word);
                r_remaining <= w_mux_bytes;
            end else if (r_state == S_LOAD) begin
                // Left-align so the first byte to send lands in [31:24].
                case (r_remaining)
                    3'd1:    r_shift <= r_shift << 24;
                    3'd2:    r_shift <= r_shift << 16;
                    3'd3:    r_shift <= r_shift << 8;
                    default: r_shift <= r_shift;
                endcase
            end else if (w_abort) begin
                r_shift     <= '0;
                r_remaining <= 3'd0;
            end else if (w_shift_en) begin
                r_shift     <= r_shift << 8;
                r_remaining <= r_remaining - 3'd1;
            end
        end
    end

    assign uart_data = r_shift[SHIFT_W-1 -: 8];
    assign tx_sent   = r_tx_sent;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_result_tx_serializer.sv
// Self-checking bench for result_tx_serializer: directed cases plus randomized
// transfers against a byte-list reference model and a simple UART responder.
module tb_result_tx_serializer;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_start;
    logic [5:0]  enables;
    logic [31:0] res [6];
    logic        uart_ready;
    logic        uart_valid;
    logic [7:0]  uart_data;
    logic        tx_sent;
    logic        busy;
    logic        timeout_err;

    result_tx_serializer #(.RES_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_start    (tx_start),
        .enables     (enables),
        .read_res    (res[0]),
        .sum_res     (res[1]),
        .avg_res     (res[2]),
        .euc_res     (res[3]),
        .man_res     (res[4]),
        .dot_res     (res[5]),
        .uart_ready  (uart_ready),
        .uart_valid  (uart_valid),
        .uart_data   (uart_data),
        .tx_sent     (tx_sent),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Monitor: records bytes, pulse counts and timing.
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int  n_valid, n_sent, first_valid_cyc, sent_cyc, start_cyc, busy_gap;
    logic busy_at_sent;
    bit  tx_active = 0;

    always @(negedge clk) begin
        if (uart_valid) begin
            got.push_back(uart_data);
            if (n_valid == 0) first_valid_cyc = cyc;
            n_valid++;
        end
        if (tx_sent) begin
            n_sent++;
            sent_cyc     = cyc;
            busy_at_sent = busy;
        end
        if (tx_active && cyc > start_cyc && n_sent == 0 && !busy) busy_gap++;
    end

    // UART responder: takes a byte, stays busy uart_lat cycles, then ready again.
    int uart_lat = 10;
    bit uart_stuck = 0;
    int rise_cyc = 0;

    initial begin
        uart_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (uart_valid) begin
                @(posedge clk);
                #1 uart_ready = 1'b0;
                if (uart_stuck) wait (!uart_stuck);
                repeat (uart_lat) @(posedge clk);
                #1 uart_ready = 1'b1;
                rise_cyc = cyc;
            end
        end
    end

    // Reference: lowest set enable picks the op; its low N bytes, MSB first.
    function automatic void build_expected(input logic [5:0] en);
        int nbytes [6] = '{1, 2, 1, 2, 3, 4};
        int sel = -1;
        exp_q.delete();
        for (int i = 0; i < 6; i++)
            if (en[i] && sel < 0) sel = i;
        if (sel < 0) return;
        for (int k = nbytes[sel] - 1; k >= 0; k--)
            exp_q.push_back(8'((res[sel] >> (8 * k)) & 32'hFF));
    endfunction

    task automatic start_tx(input logic [5:0] en);
        got.delete();
        n_valid  = 0;
        n_sent   = 0;
        busy_gap = 0;
        build_expected(en);
        @(posedge clk);
        #1;
        enables   = en;
        tx_start  = 1'b1;
        start_cyc = cyc;
        tx_active = 1;
        @(posedge clk);
        #1 tx_start = 1'b0;
    endtask

    task automatic wait_sent(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (n_sent > 0) begin
                ok = 1;
                break;
            end
        end
        tx_active = 0;
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200 && !uart_ready; i++) @(posedge clk);
        check("uart_ready_returns", uart_ready, 1'b1);
    endtask

    task automatic verify(input string tag, input bit ok, input bit chk_lat);
        check({tag, ".sent_seen"}, ok, 1'b1);
        check({tag, ".n_sent"}, n_sent, 1);
        check({tag, ".n_valid"}, n_valid, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s.byte%0d", tag, i), got[i], exp_q[i]);
        check({tag, ".busy_gap"}, busy_gap, 0);
        check({tag, ".busy_at_sent"}, busy_at_sent, 1'b0);
        if (chk_lat) begin
            if (exp_q.size() > 0) begin
                check({tag, ".first_valid_lat"}, first_valid_cyc - start_cyc, 2);
                check({tag, ".sent_after_rise"}, sent_cyc - rise_cyc, 1);
            end else begin
                check({tag, ".empty_sent_lat"}, sent_cyc - start_cyc, 2);
            end
        end
    endtask

    initial begin
        bit ok;
        logic [5:0] en;
        reset    = 1'b1;
        tx_start = 1'b0;
        enables  = '0;
        for (int i = 0; i < 6; i++) res[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.uart_valid", uart_valid, 1'b0);
        check("rst.uart_data", uart_data, 8'h00);
        check("rst.tx_sent", tx_sent, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.timeout_err", timeout_err, 1'b0);
        reset = 1'b0;

        // READ single byte
        res[0] = 32'h0000_00A5;
        start_tx(6'b000001);
        wait_sent(500, ok);
        verify("read", ok, 1);

        // DOT four bytes
        res[5] = 32'h03F8_0201;
        start_tx(6'b100000);
        wait_sent(500, ok);
        verify("dot", ok, 1);

        // MAN with mid-transfer result change and stray tx_start
        res[4] = 32'h0003_FC01;
        start_tx(6'b010000);
        for (int i = 0; i < 100 && n_valid == 0; i++) @(posedge clk);
        #1;
        res[4]   = 32'hFFFF_FFFF;
        tx_start = 1'b1;
        @(posedge clk);
        #1 tx_start = 1'b0;
        wait_sent(500, ok);
        verify("man_latched", ok, 1);
        repeat (10) @(posedge clk);
        check("man.stray_ignored", n_valid + n_sent, 4);

        // SUM + EUC: SUM wins
        res[1] = 32'h0000_01FE;
        res[3] = 32'h0000_7777;
        start_tx(6'b001010);
        wait_sent(500, ok);
        verify("sum_prio", ok, 1);

        // No op selected
        start_tx(6'b000000);
        wait_sent(50, ok);
        verify("empty", ok, 1);

        // Reset after 2nd of 4 DOT bytes
        res[5] = 32'hDEAD_BEEF;
        start_tx(6'b100000);
        for (int i = 0; i < 200 && n_valid < 2; i++) @(posedge clk);
        check("rst_mid.two_bytes", n_valid, 2);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid.uart_valid", uart_valid, 1'b0);
        check("rst_mid.uart_data", uart_data, 8'h00);
        check("rst_mid.tx_sent", tx_sent, 1'b0);
        check("rst_mid.busy", busy, 1'b0);
        reset     = 1'b0;
        tx_active = 0;
        repeat (20) @(posedge clk);
        check("rst_mid.no_sent", n_sent, 0);
        wait_ready();
        res[0] = 32'h0000_005C;
        start_tx(6'b000001);
        wait_sent(500, ok);
        verify("read_after_rst", ok, 1);

        // Randomized transfers
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 6; i++) res[i] = $urandom;
            en = (t % 3 == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
            uart_lat = $urandom_range(1, 6);
            start_tx(en);
            wait_sent(500, ok);
            verify($sformatf("rand%0d", t), ok, 1);
        end
        uart_lat = 10;

`ifdef TX_TIMEOUT_EN
        uart_stuck = 1;
        res[5] = 32'h1122_3344;
        start_tx(6'b100000);
        wait_sent(TO + 50, ok);
        check("to.sent_seen", ok, 1'b1);
        check("to.n_sent", n_sent, 1);
        check("to.n_valid", n_valid, 1);
        check("to.err", timeout_err, 1'b1);
        check("to.lat", sent_cyc - first_valid_cyc, TO + 1);
        check("to.idle", busy, 1'b0);
        uart_stuck = 0;
        wait_ready();
        check("to.sticky", timeout_err, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("to.cleared", timeout_err, 1'b0);
`else
        check("no_to.err", timeout_err, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
